// File: rtl/shot_turn_controller_if.sv
// Signal bundle between the shot/turn controller and the keyboard, ball and display blocks.
// Pulse outputs are one clk wide and come from registers. There is no back-pressure: a consumer must sample on that clk.
interface shot_turn_controller_if;
  logic       startOfFrame;
  logic       keyUp;
  logic       keyDown;
  logic       keyLeft;
  logic       keyRight;
  logic       keyFire;
  logic [3:0] ballMoving;
  logic [3:0] pocketed;
  logic       chargeUp;
  logic       chargeDown;
  logic       chargeLeft;
  logic       chargeRight;
  logic       releaseBall;
  logic       respawnWhite;
  logic       currentPlayer;
  logic       foul;
  logic [3:0] score0;
  logic [3:0] score1;
  logic       gameOver;
  logic [2:0] state;

  modport master (
    output startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyFire, ballMoving, pocketed,
    input  chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall, respawnWhite,
    input  currentPlayer, foul, score0, score1, gameOver, state
  );

  modport slave (
    input  startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyFire, ballMoving, pocketed,
    output chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall, respawnWhite,
    output currentPlayer, foul, score0, score1, gameOver, state
  );
endinterface

// File: rtl/shot_turn_controller.sv
// Turn sequencing for a two-player pool game: aim charging, shot release, roll settling,
// pocket scoring with white-ball fouls, and game-over handling.
module shot_turn_controller #(
  parameter int CHARGE_LIMIT  = 5,
  parameter int SETTLE_FRAMES = 8,
  parameter int WIN_SCORE     = 3
) (
  input  logic                  clk,
  input  logic                  resetN,
  shot_turn_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_AIM       = 3'd0,
    S_FIRE      = 3'd1,
    S_ROLL      = 3'd2,
    S_SCORE     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam int CW   = $clog2(CHARGE_LIMIT + 1) + 1;
  localparam int ST_W = $clog2(SETTLE_FRAMES + 1);
  localparam logic signed [CW-1:0] LIM_P = CW'(CHARGE_LIMIT);
  localparam logic signed [CW-1:0] LIM_N = -LIM_P;
  localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_FRAMES - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_t r_state;
  state_t w_next;

  logic signed [CW-1:0] r_ycnt;
  logic signed [CW-1:0] r_xcnt;
  logic [ST_W-1:0]      r_settle;
  logic [3:0]           r_mask;
  logic                 r_fire_prev;
  logic                 r_up;
  logic                 r_down;
  logic                 r_left;
  logic                 r_right;
  logic                 r_release;
  logic                 r_respawn;
  logic                 r_player;
  logic                 r_foul;
  logic [3:0]           r_score0;
  logic [3:0]           r_score1;
  logic                 r_game_over;

  logic       w_fire_edge;
  logic       w_charged;
  logic       w_still;
  logic       w_aim_frame;
  logic       w_up_n;
  logic       w_down_n;
  logic       w_left_n;
  logic       w_right_n;
  logic       w_release_n;
  logic       w_enter_score;
  logic [3:0] w_mask_final;
  logic [2:0] w_obj_cnt;
  logic [3:0] w_cur_score;
  logic [4:0] w_sum;
  logic [3:0] w_new_score;

  assign w_fire_edge = bus.keyFire & ~r_fire_prev;
  assign w_charged   = (r_ycnt != '0) || (r_xcnt != '0);
  assign w_still     = bus.startOfFrame && (bus.ballMoving == 4'd0);

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_AIM;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_AIM:       if (w_fire_edge && w_charged) w_next = S_FIRE;
      S_FIRE:      w_next = S_ROLL;
      S_ROLL:      if (w_still && (r_settle == SETTLE_LAST)) w_next = S_SCORE;
      S_SCORE:     w_next = ((r_score0 >= WIN) || (r_score1 >= WIN)) ? S_GAME_OVER : S_AIM;
      S_GAME_OVER: if (w_fire_edge) w_next = S_AIM;
      default:     w_next = S_AIM;
    endcase
  end

  // Output logic: next values for the registered pulses and the turn result
  always_comb begin
    w_aim_frame   = (r_state == S_AIM) && bus.startOfFrame;
    w_up_n        = w_aim_frame && bus.keyUp    && !bus.keyDown  && (r_ycnt != LIM_P);
    w_down_n      = w_aim_frame && bus.keyDown  && !bus.keyUp    && (r_ycnt != LIM_N);
    w_left_n      = w_aim_frame && bus.keyLeft  && !bus.keyRight && (r_xcnt != LIM_P);
    w_right_n     = w_aim_frame && bus.keyRight && !bus.keyLeft  && (r_xcnt != LIM_N);
    w_release_n   = (r_state == S_AIM) && (w_next == S_FIRE);
    w_enter_score = (r_state == S_ROLL) && (w_next == S_SCORE);
    // Pocket events in the settling clk still belong to this turn
    w_mask_final  = r_mask | bus.pocketed;
    w_obj_cnt     = {2'b00, w_mask_final[1]} + {2'b00, w_mask_final[2]} + {2'b00, w_mask_final[3]};
    w_cur_score   = r_player ? r_score1 : r_score0;
    w_sum         = {1'b0, w_cur_score} + {2'b00, w_obj_cnt};
    w_new_score   = w_sum[4] ? 4'hF : w_sum[3:0];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_ycnt      <= '0;
      r_xcnt      <= '0;
      r_settle    <= '0;
      r_mask      <= '0;
      r_fire_prev <= 1'b0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_left      <= 1'b0;
      r_right     <= 1'b0;
      r_release   <= 1'b0;
      r_respawn   <= 1'b0;
      r_player    <= 1'b0;
      r_foul      <= 1'b0;
      r_score0    <= '0;
      r_score1    <= '0;
      r_game_over <= 1'b0;
    end else begin
      r_fire_prev <= bus.keyFire;
      r_up        <= w_up_n;
      r_down      <= w_down_n;
      r_left      <= w_left_n;
      r_right     <= w_right_n;
      r_release   <= w_release_n;
      r_respawn   <= w_enter_score && w_mask_final[0];
      r_game_over <= (w_next == S_GAME_OVER);

      if (r_state == S_FIRE) begin
        r_ycnt   <= '0;
        r_xcnt   <= '0;
        r_settle <= '0;
        r_mask   <= '0;
      end else begin
        if (w_up_n)         r_ycnt <= r_ycnt + CW'(1);
        else if (w_down_n)  r_ycnt <= r_ycnt - CW'(1);
        if (w_left_n)       r_xcnt <= r_xcnt + CW'(1);
        else if (w_right_n) r_xcnt <= r_xcnt - CW'(1);
        if (r_state == S_ROLL) begin
          r_mask <= w_mask_final;
          if (bus.startOfFrame) begin
            if (bus.ballMoving == 4'd0) r_settle <= r_settle + ST_W'(1);
            else                        r_settle <= '0;
          end
        end
      end

      // Turn result lands on entry to SCORE so the game-over test sees updated scores
      if (w_enter_score) begin
        r_foul <= w_mask_final[0];
        if (w_mask_final[0]) begin
          r_player <= ~r_player;
        end else if (w_obj_cnt != 3'd0) begin
          if (r_player) r_score1 <= w_new_score;
          else          r_score0 <= w_new_score;
        end else begin
          r_player <= ~r_player;
        end
      end

      if ((r_state == S_GAME_OVER) && w_fire_edge) begin
        r_score0 <= '0;
        r_score1 <= '0;
        r_foul   <= 1'b0;
        r_player <= 1'b0;
      end
    end
  end

  assign bus.chargeUp      = r_up;
  assign bus.chargeDown    = r_down;
  assign bus.chargeLeft    = r_left;
  assign bus.chargeRight   = r_right;
  assign bus.releaseBall   = r_release;
  assign bus.respawnWhite  = r_respawn;
  assign bus.currentPlayer = r_player;
  assign bus.foul          = r_foul;
  assign bus.score0        = r_score0;
  assign bus.score1        = r_score1;
  assign bus.gameOver      = r_game_over;
  assign bus.state         = r_state;

endmodule

// File: doc/shot_turn_controller.md
SHOT_TURN_CONTROLLER -- requirements
Module: shot_turn_controller

Interface
REQ-001 Parameters SHALL be: CHARGE_LIMIT, default 5, max net charge steps per axis; SETTLE_FRAMES, default 8, consecutive still frames ending a roll; WIN_SCORE, default 3, score that ends the game.
REQ-002 clk  in  1  system clock.
REQ-003 resetN  in  1  reset, asynchronous, active-low.
REQ-004 startOfFrame  in  1  one-clk pulse per video frame.
REQ-005 keyUp, keyDown, keyLeft, keyRight  in  1 each  keyboard levels, synchronous to clk.
REQ-006 keyFire  in  1  fire key level.
REQ-007 ballMoving  in  4  per-ball nonzero speed; bit0 is the white ball.
REQ-008 pocketed  in  4  one-clk pocket event per ball; bit0 is the white ball.
REQ-009 chargeUp, chargeDown, chargeLeft, chargeRight  out  1 each  one-clk charge pulses to the ball movement block.
REQ-010 releaseBall  out  1  one-clk shot release pulse.
REQ-011 respawnWhite  out  1  one-clk pulse requesting white ball re-placement.
REQ-012 currentPlayer  out  1  player on turn (0/1).
REQ-013 foul  out  1  set when the last turn pocketed the white ball.
REQ-014 score0, score1  out  4 each  player scores.
REQ-015 gameOver  out  1  high in GAME_OVER.
REQ-016 state  out  3  encoding AIM=0, FIRE=1, ROLL=2, SCORE=3, GAME_OVER=4.

Function
REQ-017 AIM: on a startOfFrame cycle, each held key SHALL produce its charge pulse in the next clk, at most one pulse per key per frame.
REQ-018 Signed net counters yCnt, xCnt SHALL range -CHARGE_LIMIT..+CHARGE_LIMIT: chargeUp increments yCnt, chargeDown decrements it, chargeLeft increments xCnt, chargeRight decrements it.
REQ-019 A pulse SHALL be suppressed when it would move its counter beyond the limit.
REQ-020 If both keys of one axis are held, neither pulse of that axis SHALL be issued.
REQ-021 Rising edge of keyFire in AIM with yCnt or xCnt nonzero SHALL move to FIRE; with both zero it SHALL be ignored.
REQ-022 FIRE SHALL last one clk with releaseBall=1, clear yCnt, xCnt, settle counter and the pocket mask, and go to ROLL.
REQ-023 ROLL: on each startOfFrame, if ballMoving==0 the settle counter SHALL increment, otherwise it SHALL clear. Reaching SETTLE_FRAMES SHALL move to SCORE.
REQ-024 ROLL SHALL OR pocketed into a 4-bit turn mask; events in other states SHALL be ignored; an event in the clk of the ROLL->SCORE transition SHALL be included.
REQ-025 SCORE, one clk, with white mask bit set: foul=1, respawnWhite=1 that clk, player toggles, and object balls pocketed in the same turn SHALL NOT score.
REQ-026 SCORE without the white bit: foul=0; if any of mask[3:1] is set, the current player score SHALL add popcount(mask[3:1]) (saturating at 15) and the player keeps the turn; otherwise the player toggles.
REQ-027 After SCORE, if either score >= WIN_SCORE the next state SHALL be GAME_OVER, else AIM.
REQ-028 GAME_OVER: gameOver=1; a keyFire rising edge SHALL clear scores, foul and currentPlayer and return to AIM.
REQ-029 keyFire edge detection SHALL use a registered previous value; a key held across the return to AIM SHALL NOT refire.
REQ-030 All outputs SHALL be registered; pulse outputs SHALL be exactly one clk wide.

Reset
REQ-031 resetN low SHALL force state=AIM, all pulses 0, yCnt=xCnt=0, settle counter 0, mask 0, currentPlayer=0, foul=0, scores 0, gameOver=0, previous keyFire 0, including mid-ROLL.

Verification
REQ-032 keyUp held 7 frames in AIM -> exactly 5 chargeUp pulses, one per frame; then keyDown held 2 frames -> 2 chargeDown pulses, yCnt=3.
REQ-033 keyLeft+keyRight held 3 frames -> no horizontal pulses; keyFire edge with zero charge -> state stays AIM, no releaseBall.
REQ-034 1 chargeUp, fire -> releaseBall one clk, ROLL; ballMoving=1 for 20 frames then 0 -> SCORE exactly 8 frames after motion stops; no pocket -> currentPlayer toggles.
REQ-035 Roll with pocketed=4'b0110 (separate clks) -> score of current player +2, same player, foul=0; pocketed=4'b0011 -> foul=1, respawnWhite pulse, no score, player toggles.
REQ-036 Player 0 at score 2 pockets one ball -> score0=3, GAME_OVER, gameOver=1; keyFire edge -> scores 0, AIM.
REQ-037 resetN asserted mid-ROLL with score1=2 -> all outputs at reset values immediately, AIM after release.
